// File: rtl/sensor_arbiter.sv
// rtl/sensor_arbiter.sv - round-robin arbiter sharing one DHT11 reader among N_REQ requesters
//
// Purpose: grants the single sensor reader to one requester at a time. It enforces a
// minimum idle gap between reads and aborts reads that never finish.
// Optional feature: define SENSOR_ARB_CHECKSUM_EN to verify the frame checksum byte.
//
// Ports:
//   clock          system clock, rising edge
//   reset_n        asynchronous active-low reset
//   req            per-requester level request, held until its done pulse
//   sensor_enable  enable to the DHT11 reader, high for the whole read
//   sensor_data    40-bit frame {hum_int, hum_dec, temp_int, temp_dec, checksum}
//   sensor_error   reader protocol error flag
//   sensor_done    reader frame-complete flag
//   grant          one-hot owner of the active read, zero otherwise
//   done           one-cycle pulse to the owner when its read finishes
//   data_out       last captured frame
//   status         00 ok, 01 sensor error, 10 checksum error, 11 timeout
module sensor_arbiter #(
  parameter int N_REQ          = 4,
  parameter int GAP_CYCLES     = 100000000,
  parameter int TIMEOUT_CYCLES = 50000000
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [N_REQ-1:0] req,
  output logic             sensor_enable,
  input  logic [39:0]      sensor_data,
  input  logic             sensor_error,
  input  logic             sensor_done,
  output logic [N_REQ-1:0] grant,
  output logic [N_REQ-1:0] done,
  output logic [39:0]      data_out,
  output logic [1:0]       status
);

  localparam int MAX_CNT = (GAP_CYCLES > TIMEOUT_CYCLES) ? GAP_CYCLES : TIMEOUT_CYCLES;
  localparam int CW      = $clog2(MAX_CNT + 1);
  localparam int LW      = $clog2(N_REQ);

  localparam logic [CW-1:0]    TO_LAST   = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0]    GAP_LAST  = CW'(GAP_CYCLES - 1);
  localparam logic [LW-1:0]    LW_RESET  = LW'(N_REQ - 1);
  localparam logic [N_REQ-1:0] ONE_HOT_0 = {{(N_REQ-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    GAP  = 2'b10
  } state_t;

  state_t            state, state_nxt;
  logic [CW-1:0]     cnt, cnt_nxt;
  logic [LW-1:0]     last_winner, last_winner_nxt;
  logic [LW-1:0]     winner;
  logic [N_REQ-1:0]  grant_nxt, done_nxt;
  logic              enable_nxt;
  logic [39:0]       data_nxt;
  logic [1:0]        status_nxt;
  logic              finish;
  logic              cks_bad;

`ifdef SENSOR_ARB_CHECKSUM_EN
  logic [7:0] cks_sum;
  assign cks_sum = sensor_data[39:32] + sensor_data[31:24] + sensor_data[23:16] + sensor_data[15:8];
  assign cks_bad = (cks_sum != sensor_data[7:0]);
`else
  assign cks_bad = 1'b0;
`endif

  // Round-robin search starting just after the previous winner, so a requester that
  // keeps its request high is served again only after every other pending one.
  always_comb begin
    logic found;
    int   idx;
    found  = 1'b0;
    winner = last_winner;
    for (int i = 1; i <= N_REQ; i++) begin
      idx = (int'(last_winner) + i) % N_REQ;
      if (!found && req[LW'(idx)]) begin
        found  = 1'b1;
        winner = LW'(idx);
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt       = state;
    cnt_nxt         = cnt;
    last_winner_nxt = last_winner;
    grant_nxt       = grant;
    enable_nxt      = sensor_enable;
    done_nxt        = '0;
    data_nxt        = data_out;
    status_nxt      = status;
    finish          = 1'b0;
    case (state)
      IDLE: begin
        if (|req) begin
          grant_nxt       = ONE_HOT_0 << winner;
          enable_nxt      = 1'b1;
          last_winner_nxt = winner;
          cnt_nxt         = '0;
          state_nxt       = BUSY;
        end
      end
      BUSY: begin
        cnt_nxt = cnt + CW'(1);
        // Error beats done; done beats the timeout terminal count.
        if (sensor_error) begin
          status_nxt = 2'b01;
          finish     = 1'b1;
        end else if (sensor_done) begin
          data_nxt   = sensor_data;
          status_nxt = cks_bad ? 2'b10 : 2'b00;
          finish     = 1'b1;
        end else if (cnt == TO_LAST) begin
          status_nxt = 2'b11;
          finish     = 1'b1;
        end
        if (finish) begin
          done_nxt   = grant;
          grant_nxt  = '0;
          enable_nxt = 1'b0;
          cnt_nxt    = '0;
          state_nxt  = GAP;
        end
      end
      GAP: begin
        if (cnt == GAP_LAST) begin
          cnt_nxt   = '0;
          state_nxt = IDLE;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      default: begin
        state_nxt  = IDLE;
        grant_nxt  = '0;
        enable_nxt = 1'b0;
        cnt_nxt    = '0;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt           <= '0;
      last_winner   <= LW_RESET;
      grant         <= '0;
      sensor_enable <= 1'b0;
      done          <= '0;
      data_out      <= '0;
      status        <= 2'b00;
    end else begin
      cnt           <= cnt_nxt;
      last_winner   <= last_winner_nxt;
      grant         <= grant_nxt;
      sensor_enable <= enable_nxt;
      done          <= done_nxt;
      data_out      <= data_nxt;
      status        <= status_nxt;
    end
  end

endmodule
